mmio_hub: RTL and testbench
===========================

MMIO_HUB -- requirements
Module: mmio_hub

Interface
REQ-001 Parameter BASE_ADDR, default 19456, 15-bit word address of register offset 0.
REQ-002 Parameter NUM_SENSORS, default 2, legal range 1..4, number of sensor channels.
REQ-003 Parameter LED_W, default 8, legal range 1..16, LED register width.
REQ-004 clk  input  1  system clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset; asynchronous and active-low.
REQ-006 addr_valid  input  1  access strobe; exactly one access per high cycle.
REQ-007 address_in  input  24  bit 23 = write (1) / read (0); bits [14:0] = word address; bits [22:15] ignored.
REQ-008 wdata  input  16  write data, sampled when addr_valid and address_in[23] are both 1.
REQ-009 sensor_ready  input  NUM_SENSORS  per-channel one-cycle capture strobe.
REQ-010 sensor_data  input  16*NUM_SENSORS  channel i occupies bits [16i+15:16i].
REQ-011 buttons_in  input  16  asynchronous raw button levels.
REQ-012 data_out  output  16  registered read data.
REQ-013 data_valid  output  1  high for one cycle when data_out holds a read result.
REQ-014 leds_out  output  LED_W  LED register contents.
REQ-015 irq  output  1  registered level interrupt.

Function
REQ-016 Register map (offset = address_in[14:0] - BASE_ADDR): 0 BTN (RO), 1 EDGE (RO, read-clear), 2 STAT (RO), 3 LED (RW), 4 IRQEN (RW, bits[1:0]), 5..4+NUM_SENSORS SENS[i] (RO).
REQ-017 Address matching uses all 15 bits; any address outside the map is unmapped.
REQ-018 buttons_in passes through a 2-flop synchronizer; BTN = second-stage value; total delay 2 cycles.
REQ-019 A rising edge is a 0-to-1 transition of any BTN bit between consecutive cycles; it sets the matching EDGE bit (sticky).
REQ-020 When sensor_ready[i] is 1, SENS[i] <= channel i of sensor_data and STAT[i] <= 1 in the same edge; STAT bits [15:NUM_SENSORS] read 0.
REQ-021 Read (addr_valid=1, bit 23=0): data_out = addressed register and data_valid = 1 on the next cycle; unmapped addresses return 0 with data_valid = 1.
REQ-022 A read returns the register value from before that cycle's updates; a same-cycle capture or edge is not visible until the next read.
REQ-023 Reading EDGE clears all its bits at the read edge; edges detected in the same cycle remain set (set wins).
REQ-024 Reading SENS[i] clears STAT[i]; if sensor_ready[i] is 1 in the same cycle, STAT[i] stays 1 and SENS[i] takes the new data.
REQ-025 Write (addr_valid=1, bit 23=1): LED <= wdata[LED_W-1:0] and IRQEN <= wdata[1:0]; writes to RO or unmapped addresses are ignored.
REQ-026 On a write, data_valid = 0 next cycle and data_out holds its previous value.
REQ-027 With addr_valid=0: no register side effects; data_valid = 0; data_out holds its value.
REQ-028 leds_out = LED register directly; a write is visible 1 cycle after the access.
REQ-029 irq (registered) <= (IRQEN[0] & |EDGE) | (IRQEN[1] & |STAT), using post-update register values; 1 cycle behind the cause.
REQ-030 Back-to-back accesses in consecutive cycles are fully supported; there is no stall and no ready signal.

Reset
REQ-031 rst_n low asynchronously forces all registers to 0: synchronizer, BTN, EDGE, STAT, SENS, LED, IRQEN, data_out, data_valid, irq.
REQ-032 Reset mid-access aborts the access; after release, the first rising edge with addr_valid=1 is processed normally.
REQ-033 BTN history resets to 0, so a button already held at release registers one rising edge 2-3 cycles later.

Verification
REQ-034 Reset then read LED (BASE+3) -> data_out=0x0000, data_valid=1 one cycle later; leds_out=0.
REQ-035 Write 0x00A5 to BASE+3, read back -> leds_out=0xA5 one cycle after the write; read returns 0x00A5; write cycle gives data_valid=0.
REQ-036 sensor_ready[1] with data 0x1234 -> STAT=0x0002; read BASE+6 -> 0x1234 and STAT=0; a read coinciding with a new ready -> returns old data, STAT stays 0x0002.
REQ-037 buttons_in bit3 goes 0->1 -> EDGE=0x0008 within 3 cycles; with IRQEN=1 -> irq=1; read EDGE -> 0x0008 then EDGE=0 and irq drops the next cycle.
REQ-038 Read BASE+200 (unmapped) and write to BASE+0 -> read returns 0x0000 with data_valid=1; BTN unchanged.
REQ-039 Assert rst_n low mid-sequence with LED=0xFF and STAT≠0 -> all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/mmio_hub.sv
// Memory-mapped peripheral hub: synchronised buttons with sticky rising-edge flags,
// sensor capture registers with status bits, an LED register and a level interrupt.
module mmio_hub #(
    parameter logic [14:0] BASE_ADDR   = 15'd19456,
    parameter int          NUM_SENSORS = 2,
    parameter int          LED_W       = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     addr_valid,
    input  logic [23:0]              address_in,
    input  logic [15:0]              wdata,
    input  logic [NUM_SENSORS-1:0]   sensor_ready,
    input  logic [16*NUM_SENSORS-1:0] sensor_data,
    input  logic [15:0]              buttons_in,
    output logic [15:0]              data_out,
    output logic                     data_valid,
    output logic [LED_W-1:0]         leds_out,
    output logic                     irq
);

    logic [15:0]            sync_p0;
    logic [15:0]            btn_p1;
    logic [15:0]            btn_dly_p2;
    logic [15:0]            edge_q;
    logic [NUM_SENSORS-1:0] stat_q;
    logic [15:0]            sens_q [NUM_SENSORS];
    logic [LED_W-1:0]       led_q;
    logic [1:0]             irqen_q;

    logic [14:0]            offset;
    logic                   rd_stb;
    logic                   wr_stb;
    logic [15:0]            rise;
    logic [15:0]            edge_next;
    logic [NUM_SENSORS-1:0] stat_next;
    logic [1:0]             irqen_next;
    logic                   irq_next;
    logic [15:0]            rd_data;
    logic                   unused_bits;

    assign unused_bits = ^{address_in[22:15], wdata};

    // Offset arithmetic wraps modulo 2^15, so addresses below the base land far outside the map.
    assign offset = address_in[14:0] - BASE_ADDR;
    assign rd_stb = addr_valid & ~address_in[23];
    assign wr_stb = addr_valid &  address_in[23];
    assign rise   = btn_p1 & ~btn_dly_p2;

    always_comb begin
        edge_next  = edge_q | rise;
        irqen_next = irqen_q;
        stat_next  = stat_q;
        if (rd_stb && offset == 15'd1)
            edge_next = rise;
        if (wr_stb && offset == 15'd4)
            irqen_next = wdata[1:0];
        for (int i = 0; i < NUM_SENSORS; i++) begin
            if (rd_stb && offset == 15'(5 + i))
                stat_next[i] = 1'b0;
            if (sensor_ready[i])
                stat_next[i] = 1'b1;
        end
        irq_next = (irqen_next[0] & |edge_next) | (irqen_next[1] & |stat_next);
    end

    // Read mux sees register values from before this cycle's updates.
    always_comb begin
        rd_data = '0;
        if (offset == 15'd0)
            rd_data = btn_p1;
        else if (offset == 15'd1)
            rd_data = edge_q;
        else if (offset == 15'd2)
            rd_data[NUM_SENSORS-1:0] = stat_q;
        else if (offset == 15'd3)
            rd_data[LED_W-1:0] = led_q;
        else if (offset == 15'd4)
            rd_data[1:0] = irqen_q;
        else begin
            for (int i = 0; i < NUM_SENSORS; i++) begin
                if (offset == 15'(5 + i))
                    rd_data = sens_q[i];
            end
        end
    end

    // Stage p0/p1: button synchroniser; p2: previous BTN for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0    <= '0;
            btn_p1     <= '0;
            btn_dly_p2 <= '0;
        end else begin
            sync_p0    <= buttons_in;
            btn_p1     <= sync_p0;
            btn_dly_p2 <= btn_p1;
        end
    end

    // Register file and bus response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_q     <= '0;
            stat_q     <= '0;
            led_q      <= '0;
            irqen_q    <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            irq        <= 1'b0;
            for (int i = 0; i < NUM_SENSORS; i++)
                sens_q[i] <= '0;
        end else begin
            edge_q     <= edge_next;
            stat_q     <= stat_next;
            irqen_q    <= irqen_next;
            irq        <= irq_next;
            data_valid <= rd_stb;
            if (rd_stb)
                data_out <= rd_data;
            if (wr_stb && offset == 15'd3)
                led_q <= wdata[LED_W-1:0];
            for (int i = 0; i < NUM_SENSORS; i++) begin
                if (sensor_ready[i])
                    sens_q[i] <= sensor_data[16*i +: 16];
            end
        end
    end

    assign leds_out = led_q;

endmodule

// File: tb/tb_mmio_hub.sv
// Directed self-checking bench for mmio_hub with default parameters.
module tb_mmio_hub;

    localparam logic [14:0] BASE = 15'd19456;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        addr_valid;
    logic [23:0] address_in;
    logic [15:0] wdata;
    logic [1:0]  sensor_ready;
    logic [31:0] sensor_data;
    logic [15:0] buttons_in;
    logic [15:0] data_out;
    logic        data_valid;
    logic [7:0]  leds_out;
    logic        irq;

    int total = 0;
    int bad   = 0;

    mmio_hub #(.BASE_ADDR(BASE), .NUM_SENSORS(2), .LED_W(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .addr_valid   (addr_valid),
        .address_in   (address_in),
        .wdata        (wdata),
        .sensor_ready (sensor_ready),
        .sensor_data  (sensor_data),
        .buttons_in   (buttons_in),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .leds_out     (leds_out),
        .irq          (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [14:0] off);
        addr_valid = 1'b1;
        address_in = {1'b0, 8'h00, BASE + off};
        cyc();
        addr_valid = 1'b0;
    endtask

    task automatic wr(input logic [14:0] off, input logic [15:0] d);
        addr_valid = 1'b1;
        address_in = {1'b1, 8'h00, BASE + off};
        wdata      = d;
        cyc();
        addr_valid = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [14:0] off, input logic [15:0] exp);
        rd(off);
        check({tag, "_data"}, data_out, exp);
        check({tag, "_dv"}, {15'd0, data_valid}, 16'd1);
    endtask

    initial begin
        rst_n        = 1'b0;
        addr_valid   = 1'b0;
        address_in   = '0;
        wdata        = '0;
        sensor_ready = '0;
        sensor_data  = '0;
        buttons_in   = '0;
        #3;
        check("rst_dout", data_out, 16'h0000);
        check("rst_dv", {15'd0, data_valid}, 16'd0);
        check("rst_leds", {8'd0, leds_out}, 16'h0000);
        check("rst_irq", {15'd0, irq}, 16'd0);
        cyc();
        cyc();
        rst_n = 1'b1;

        // LED reset value and write/readback
        rd_chk("led_init", 15'd3, 16'h0000);
        check("led_init_leds", {8'd0, leds_out}, 16'h0000);
        wr(15'd3, 16'h00A5);
        check("wr_leds", {8'd0, leds_out}, 16'h00A5);
        check("wr_dv", {15'd0, data_valid}, 16'd0);
        check("wr_dout_hold", data_out, 16'h0000);
        rd_chk("led_rb", 15'd3, 16'h00A5);
        cyc();
        check("idle_dv", {15'd0, data_valid}, 16'd0);
        check("idle_dout_hold", data_out, 16'h00A5);

        // Sensor capture, status clear, and read coinciding with a new capture
        sensor_data  = {16'h1234, 16'h0000};
        sensor_ready = 2'b10;
        cyc();
        sensor_ready = 2'b00;
        rd_chk("stat_set", 15'd2, 16'h0002);
        rd_chk("sens1", 15'd6, 16'h1234);
        rd_chk("stat_clr", 15'd2, 16'h0000);
        rd_chk("sens0", 15'd5, 16'h0000);
        sensor_data  = {16'h5678, 16'h0000};
        sensor_ready = 2'b10;
        rd_chk("sens1_old", 15'd6, 16'h1234);
        sensor_ready = 2'b00;
        rd_chk("stat_kept", 15'd2, 16'h0002);
        rd_chk("sens1_new", 15'd6, 16'h5678);
        check("irq_dis", {15'd0, irq}, 16'd0);

        // Button edge and edge interrupt
        wr(15'd4, 16'h0001);
        rd_chk("irqen_rb", 15'd4, 16'h0001);
        buttons_in = 16'h0008;
        cyc();
        cyc();
        check("irq_early", {15'd0, irq}, 16'd0);
        cyc();
        check("irq_edge", {15'd0, irq}, 16'd1);
        rd_chk("edge_rd", 15'd1, 16'h0008);
        check("irq_drop", {15'd0, irq}, 16'd0);
        rd_chk("edge_clr", 15'd1, 16'h0000);
        rd_chk("btn", 15'd0, 16'h0008);

        // Status interrupt
        wr(15'd4, 16'h0002);
        sensor_data  = {16'h5678, 16'hBEEF};
        sensor_ready = 2'b01;
        cyc();
        sensor_ready = 2'b00;
        check("irq_stat", {15'd0, irq}, 16'd1);
        rd_chk("sens0_cap", 15'd5, 16'hBEEF);
        check("irq_stat_drop", {15'd0, irq}, 16'd0);

        // Unmapped reads, ignored RO write, ignored upper address bits
        rd_chk("unmap200", 15'd200, 16'h0000);
        rd_chk("unmap7", 15'd7, 16'h0000);
        rd_chk("unmap_below", 15'h7FFF, 16'h0000);
        wr(15'd0, 16'hFFFF);
        rd_chk("btn_ro", 15'd0, 16'h0008);
        addr_valid = 1'b1;
        address_in = {1'b0, 8'hFF, BASE + 15'd3};
        cyc();
        addr_valid = 1'b0;
        check("hibits_led", data_out, 16'h00A5);

        // Asynchronous reset in the middle of an access
        wr(15'd3, 16'h00FF);
        sensor_ready = 2'b10;
        rd_chk("pre_rst_led", 15'd3, 16'h00FF);
        sensor_ready = 2'b00;
        check("pre_rst_irq", {15'd0, irq}, 16'd1);
        addr_valid = 1'b1;
        address_in = {1'b0, 8'h00, BASE + 15'd2};
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_dout", data_out, 16'h0000);
        check("arst_dv", {15'd0, data_valid}, 16'd0);
        check("arst_leds", {8'd0, leds_out}, 16'h0000);
        check("arst_irq", {15'd0, irq}, 16'd0);
        addr_valid = 1'b0;
        cyc();
        rst_n = 1'b1;

        // Button held through reset produces one edge on the third edge after release
        cyc();
        cyc();
        rd_chk("held_edge_pre", 15'd1, 16'h0000);
        rd_chk("held_edge", 15'd1, 16'h0008);
        rd_chk("post_rst_led", 15'd3, 16'h0000);
        rd_chk("post_rst_stat", 15'd2, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
